// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select and load-use stall/bubble controller with private pipeline shadows.
// Define FWD_STATS_EN to add the stall_cnt / fwd_cnt statistics outputs.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall,
    output logic                  bubble
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           fwd_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [REG_ADDR_W:0]   REG_LIMIT = (REG_ADDR_W + 1)'(NUM_REGS);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = {REG_ADDR_W{1'b0}};

    state_t                  state_r, state_nxt_s;

    logic                    idex_valid_r, idex_use1_r, idex_use2_r;
    logic                    idex_regwrite_r, idex_memread_r;
    logic [REG_ADDR_W-1:0]   idex_rs1_r, idex_rs2_r, idex_rd_r;
    logic                    exmem_valid_r, exmem_regwrite_r, exmem_memread_r;
    logic [REG_ADDR_W-1:0]   exmem_rd_r;
    logic                    memwb_valid_r, memwb_regwrite_r;
    logic [REG_ADDR_W-1:0]   memwb_rd_r;
    logic                    hazard_s;

    // x0 and indices beyond the architectural file never carry forwarded data
    function automatic logic reg_live(input logic [REG_ADDR_W-1:0] r);
        return (r != REG_ZERO) && ({1'b0, r} < REG_LIMIT);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_ADDR_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (idex_valid_r && use_src && reg_live(src)) begin
            if (exmem_valid_r && exmem_regwrite_r && !exmem_memread_r && (exmem_rd_r == src)) begin
                sel = 2'b10;
            end else if (memwb_valid_r && memwb_regwrite_r && (memwb_rd_r == src)) begin
                sel = 2'b01;
            end else begin
                sel = 2'b00;
            end
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Operand selects for the instruction currently in EX
    always_comb begin
        forward_a = fwd_sel(idex_use1_r, idex_rs1_r);
        forward_b = fwd_sel(idex_use2_r, idex_rs2_r);
    end

    // Consumer in decode reads the destination of a load sitting in ID/EX
    always_comb begin
        hazard_s = id_valid && idex_valid_r && idex_memread_r && (idex_rd_r != REG_ZERO) &&
                   ((id_use_rs1 && (id_rs1 == idex_rd_r)) || (id_use_rs2 && (id_rs2 == idex_rd_r)));
    end

    // Load-use next state and stall/bubble decode
    always_comb begin
        state_nxt_s = ST_RUN;
        stall       = 1'b0;
        bubble      = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (hazard_s && !flush) begin
                    stall       = 1'b1;
                    bubble      = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HOLD: state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Load-use state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Destination-register shadows advance one stage per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_valid_r     <= 1'b0;
            idex_use1_r      <= 1'b0;
            idex_use2_r      <= 1'b0;
            idex_regwrite_r  <= 1'b0;
            idex_memread_r   <= 1'b0;
            idex_rs1_r       <= REG_ZERO;
            idex_rs2_r       <= REG_ZERO;
            idex_rd_r        <= REG_ZERO;
            exmem_valid_r    <= 1'b0;
            exmem_regwrite_r <= 1'b0;
            exmem_memread_r  <= 1'b0;
            exmem_rd_r       <= REG_ZERO;
            memwb_valid_r    <= 1'b0;
            memwb_regwrite_r <= 1'b0;
            memwb_rd_r       <= REG_ZERO;
        end else begin
            memwb_valid_r    <= exmem_valid_r;
            memwb_regwrite_r <= exmem_regwrite_r;
            memwb_rd_r       <= exmem_rd_r;
            exmem_valid_r    <= idex_valid_r;
            exmem_regwrite_r <= idex_regwrite_r;
            exmem_memread_r  <= idex_memread_r;
            exmem_rd_r       <= idex_rd_r;
            if (id_valid && !stall && !flush) begin
                idex_valid_r    <= 1'b1;
                idex_use1_r     <= id_use_rs1;
                idex_use2_r     <= id_use_rs2;
                idex_regwrite_r <= id_regwrite;
                idex_memread_r  <= id_memread;
                idex_rs1_r      <= id_rs1;
                idex_rs2_r      <= id_rs2;
                idex_rd_r       <= id_rd;
            end else begin
                idex_valid_r    <= 1'b0;
            end
        end
    end

`ifdef FWD_STATS_EN
    logic [1:0] fwd_inc_s;

    // Number of operands forwarded this cycle
    always_comb begin
        fwd_inc_s = {1'b0, (forward_a != 2'b00)} + {1'b0, (forward_b != 2'b00)};
    end

    // Free-running statistics, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            fwd_cnt   <= 32'd0;
        end else begin
            stall_cnt <= stall_cnt + {31'd0, stall};
            fwd_cnt   <= fwd_cnt + {30'd0, fwd_inc_s};
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed pipeline scenarios then randomized traffic.
module tb_fwd_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ins_t;

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic        bu;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic        id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
    logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic [1:0]  forward_a, forward_b;
    logic        stall, bubble;
    logic [31:0] stall_cnt_obs, fwd_cnt_obs;

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt;
    assign stall_cnt_obs = stall_cnt;
    assign fwd_cnt_obs   = fwd_cnt;
`else
    assign stall_cnt_obs = 32'd0;
    assign fwd_cnt_obs   = 32'd0;
`endif

    fwd_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall(stall), .bubble(bubble)
`ifdef FWD_STATS_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: pipe[0]=instruction in EX, pipe[1]=one ahead (MEM), pipe[2]=two ahead (WB)
    ins_t        pipe [3];
    logic        held;
    logic [31:0] m_sc, m_fc;
    exp_t        sb_q [$];
    int          issued = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic        last_stall = 1'b0;

    function automatic ins_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic [4:0] rd, logic rw, logic mr);
        ins_t i;
        i = '{v: v, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, rw: rw, mr: mr};
        return i;
    endfunction

    function automatic logic [1:0] m_sel(logic u, logic [4:0] rs);
        if (!pipe[0].v || !u || rs == 5'd0) return 2'b00;
        if (pipe[1].v && pipe[1].rw && !pipe[1].mr && pipe[1].rd == rs) return 2'b10;
        if (pipe[2].v && pipe[2].rw && pipe[2].rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        held = 1'b0;
        m_sc = 32'd0;
        m_fc = 32'd0;
    endtask

    // Drive one decode cycle, predict the response, and advance the model across the next edge
    task automatic apply(ins_t i, logic fl, logic r);
        exp_t e;
        logic haz, st;
        @(posedge clk);
        #1;
        id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_use_rs1 = i.u1; id_use_rs2 = i.u2;
        id_rd = i.rd; id_regwrite = i.rw; id_memread = i.mr; flush = fl; rst = r;
        haz = i.v && pipe[0].v && pipe[0].mr && pipe[0].rd != 5'd0 &&
              ((i.u1 && i.rs1 == pipe[0].rd) || (i.u2 && i.rs2 == pipe[0].rd));
        st = haz && !fl && !held;
        e.fa = m_sel(pipe[0].u1, pipe[0].rs1);
        e.fb = m_sel(pipe[0].u2, pipe[0].rs2);
        e.st = st;
        e.bu = st;
        e.sc = m_sc;
        e.fc = m_fc;
        sb_q.push_back(e);
        issued++;
        last_stall = st;
        if (r) begin
            model_reset();
        end else begin
            m_sc = m_sc + 32'(st);
            m_fc = m_fc + 32'(e.fa != 2'b00) + 32'(e.fb != 2'b00);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (i.v && !st && !fl) ? i : ins_t'('0);
            held = st;
        end
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at vector %0d: got %0h, expected %0h", name, vectors, got, want);
        end
    endtask

    // Monitor: compare every presented response against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vectors++;
                check("forward_a", 32'(forward_a), 32'(e.fa));
                check("forward_b", 32'(forward_b), 32'(e.fb));
                check("stall", 32'(stall), 32'(e.st));
                check("bubble", 32'(bubble), 32'(e.bu));
`ifdef FWD_STATS_EN
                check("stall_cnt", stall_cnt_obs, e.sc);
                check("fwd_cnt", fwd_cnt_obs, e.fc);
`endif
            end
        end
    end

    initial begin
        ins_t nop, cur;
        logic fl, r;
        nop = '0;
        model_reset();
        repeat (2) @(posedge clk);
        // Reset state with idle decode
        repeat (2) apply(nop, 1'b0, 1'b0);
        // add x5 ; sub x6,x5,x1
        apply(mk(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0), 1'b0, 1'b0);
        apply(mk(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0), 1'b0, 1'b0);
        repeat (3) apply(nop, 1'b0, 1'b0);
        // add x5 ; nop ; or x7,x1,x5
        apply(mk(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0), 1'b0, 1'b0);
        apply(nop, 1'b0, 1'b0);
        apply(mk(1, 5'd1, 5'd5, 1, 1, 5'd7, 1, 0), 1'b0, 1'b0);
        repeat (3) apply(nop, 1'b0, 1'b0);
        // add x5 ; add x5 ; and x8,x5,x5
        apply(mk(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0), 1'b0, 1'b0);
        apply(mk(1, 5'd3, 5'd4, 1, 1, 5'd5, 1, 0), 1'b0, 1'b0);
        apply(mk(1, 5'd5, 5'd5, 1, 1, 5'd8, 1, 0), 1'b0, 1'b0);
        repeat (3) apply(nop, 1'b0, 1'b0);
        // lw x9 ; add x10,x9,x2 (stalled once, then re-decoded)
        apply(mk(1, 5'd3, 5'd0, 1, 0, 5'd9, 1, 1), 1'b0, 1'b0);
        repeat (2) apply(mk(1, 5'd9, 5'd2, 1, 1, 5'd10, 1, 0), 1'b0, 1'b0);
        repeat (3) apply(nop, 1'b0, 1'b0);
        // x0 destinations: add x0 ; sub x3,x0,x0 ; lw x0 ; use of x0
        apply(mk(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0), 1'b0, 1'b0);
        apply(mk(1, 5'd0, 5'd0, 1, 1, 5'd3, 1, 0), 1'b0, 1'b0);
        apply(mk(1, 5'd3, 5'd0, 1, 0, 5'd0, 1, 1), 1'b0, 1'b0);
        apply(mk(1, 5'd0, 5'd0, 1, 1, 5'd4, 1, 0), 1'b0, 1'b0);
        repeat (3) apply(nop, 1'b0, 1'b0);
        // flush together with a load-use hazard
        apply(mk(1, 5'd3, 5'd0, 1, 0, 5'd9, 1, 1), 1'b0, 1'b0);
        apply(mk(1, 5'd9, 5'd2, 1, 1, 5'd10, 1, 0), 1'b1, 1'b0);
        repeat (2) apply(nop, 1'b0, 1'b0);
        // back-to-back dependent loads stall once
        apply(mk(1, 5'd3, 5'd0, 1, 0, 5'd1, 1, 1), 1'b0, 1'b0);
        repeat (2) apply(mk(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1), 1'b0, 1'b0);
        repeat (3) apply(nop, 1'b0, 1'b0);
        // reset pulsed while in HOLD
        apply(mk(1, 5'd3, 5'd0, 1, 0, 5'd9, 1, 1), 1'b0, 1'b0);
        apply(mk(1, 5'd9, 5'd2, 1, 1, 5'd10, 1, 0), 1'b0, 1'b0);
        apply(mk(1, 5'd9, 5'd2, 1, 1, 5'd10, 1, 0), 1'b0, 1'b1);
        repeat (2) apply(mk(1, 5'd9, 5'd2, 1, 1, 5'd10, 1, 0), 1'b0, 1'b0);

        // Randomized traffic over a small register window to make dependencies frequent
        cur = nop;
        for (int n = 0; n < 3000; n++) begin
            fl = ($urandom_range(0, 11) == 0);
            r  = ($urandom_range(0, 59) == 0);
            if (!(last_stall && !fl)) begin
                cur.v   = ($urandom_range(0, 99) < 85);
                cur.rs1 = 5'($urandom_range(0, 3));
                cur.rs2 = 5'($urandom_range(0, 3));
                cur.u1  = 1'($urandom_range(0, 1));
                cur.u2  = 1'($urandom_range(0, 1));
                cur.rd  = 5'($urandom_range(0, 3));
                cur.rw  = ($urandom_range(0, 9) < 7);
                cur.mr  = ($urandom_range(0, 9) < 3);
            end
            apply(cur, fl, r);
        end
        apply(nop, 1'b0, 1'b0);

        // Bounded drain of the scoreboard
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d responses left unchecked, expected 0", sb_q.size());
        end
        if (vectors != issued) begin
            miscompares++;
            $display("FAIL count: checked %0d, expected %0d", vectors, issued);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
